spi_rr_arbiter: RTL

- Shares one spi_master/slave datapath (new_data/din in, done/dout out) among NUM_REQ requesters.
- Grants are round-robin, one 12-bit transaction at a time.
- Sequences the new_data strobe for the master, waits for done, and returns dout to the winning requester.
- A watchdog covers a missing done.
- Sits between the client logic and the SPI top.

---
 rtl/spi_rr_arbiter_if.sv | 28 ++
 rtl/spi_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/spi_rr_arbiter_if.sv
// Bundle between the client requesters, the round-robin arbiter and the SPI top.
// The arbiter connects through master; the client/SPI side through slave.
interface spi_rr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          busy;
  logic                          new_data;
  logic [DATA_WIDTH-1:0]         din;
  logic                          done;
  logic [DATA_WIDTH-1:0]         dout;

  modport master (
    input  req, req_data, done, dout,
    output grant, rsp_valid, rsp_data, rsp_err, busy, new_data, din
  );

  modport slave (
    output req, req_data, done, dout,
    input  grant, rsp_valid, rsp_data, rsp_err, busy, new_data, din
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter sharing one SPI master datapath among NUM_REQ requesters,
// one word per grant, with a watchdog that completes a transfer whose done never comes.
module spi_rr_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned NEW_DATA_CYCLES = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input logic               clk,
  input logic               reset,
  spi_rr_arbiter_if.master  bus
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LCNT_W = $clog2(NEW_DATA_CYCLES + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_REQ - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(NEW_DATA_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  busy_q;
  logic                  new_data_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [LCNT_W-1:0]     launch_cnt_q;
  logic [TCNT_W-1:0]     to_cnt_q;

  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      ptr_d;
  logic                  win_found;
  logic [DATA_WIDTH-1:0] din_d;
  logic [NUM_REQ-1:0]    grant_d;

  // First requester at or after ptr+1 (with wrap) wins; last winner is lowest priority.
  always_comb begin
    cand      = ptr_q;
    ptr_d     = ptr_q;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if ((32'(ptr_q) + k) >= NUM_REQ) begin
        cand = PTR_W'(32'(ptr_q) + k - NUM_REQ);
      end else begin
        cand = PTR_W'(32'(ptr_q) + k);
      end
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        ptr_d     = cand;
      end
    end
    din_d   = bus.req_data[ptr_d*DATA_WIDTH +: DATA_WIDTH];
    grant_d = NUM_REQ'(1) << ptr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_RST;
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      new_data_q   <= 1'b0;
      din_q        <= '0;
      launch_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q      <= grant_d;
            din_q        <= din_d;
            ptr_q        <= ptr_d;
            new_data_q   <= 1'b1;
            busy_q       <= 1'b1;
            launch_cnt_q <= '0;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (launch_cnt_q == LCNT_LAST) begin
            new_data_q <= 1'b0;
            to_cnt_q   <= '0;
            state_q    <= S_WAIT;
          end else begin
            launch_cnt_q <= launch_cnt_q + LCNT_W'(1);
          end
        end
        // done takes precedence over a watchdog expiry in the same cycle
        S_WAIT: begin
          if (bus.done) begin
            rsp_data_q  <= bus.dout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= grant_q;
            state_q     <= S_RESP;
          end else if (to_cnt_q == TCNT_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_q;
            state_q     <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TCNT_W'(1);
          end
        end
        S_RESP: begin
          grant_q     <= '0;
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.new_data  = new_data_q;
  assign bus.din       = din_q;

endmodule
